mips_memory_access_aligner: RTL and testbench
=============================================

# mips_memory_access_aligner

Parametrised successor to the fixed byte-enable decoder, sitting between the MEM pipeline stage and the data-memory bus. Accepts one load/store request at a time, generates address-shifted byte enables and aligned write data, and splits any access that crosses a bus-word boundary into two bus beats. Reassembles and extends load data, then returns it through a valid/ready response port.

## Interface
Parameters:
- `BYTES`, 4: bus width in bytes; power of two, ≥4.
- `ADDR_W`, 32: address width.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `reqValid` / `reqReady`  in / out  1  request handshake.
- `reqAddr`  in  ADDR_W  byte address.
- `reqSize`  in  2  access size: None=0, Byte=1, Half=2, Word=3.
- `reqWrite`  in  1  1 = store.
- `reqSigned`  in  1  sign-extend load result.
- `reqData`  in  8*BYTES  store data, right-aligned.
- `busValid`  out  1  bus beat request.
- `busAck`  in  1  beat complete; `busRData` valid this cycle.
- `busAddr`  out  ADDR_W  aligned address; low log2(BYTES) bits are 0.
- `busWrite`  out  1  beat is a store.
- `busByteEnable`  out  BYTES  lane enables.
- `busWData`  out  8*BYTES  lane-aligned store data.
- `busRData`  in  8*BYTES  read data.
- `respValid` / `respReady`  out / in  1  response handshake.
- `respData`  out  8*BYTES  right-aligned, extended load data; 0 for stores and None.

## Operation
- Latched at acceptance: `off = addr mod BYTES`, `n` = 0/1/2/4 bytes, `mask = (1<<n)-1`.
- `split = (off + n > BYTES)`.
- Store data: `wide = reqData << 8*off`, width 2*BYTES bytes.
  - Beat 1 uses the low half.
  - Beat 2 uses the high half.
- Byte enables: `wideBE = mask << off`, width 2*BYTES.
  - Beat 1 uses `wideBE[BYTES-1:0]`.
  - Beat 2 uses the upper half.
- Beat addresses:
  - Beat 1: `addr & ~(BYTES-1)`.
  - Beat 2: beat-1 address + BYTES, wrapping modulo 2^ADDR_W.
- Load assembly: `({beat2, beat1} >> 8*off)`, truncated to n bytes.
  - `reqSigned` replicates bit 8n-1 upward; otherwise zero-extend.
  - For non-split accesses, beat2 = 0.
- FSM states: IDLE, BEAT1, BEAT2, RESP.
  - IDLE: `reqReady=1`. On accept, go to RESP if size is None, else BEAT1.
  - BEAT1: `busValid=1`. On `busAck`, go to BEAT2 if `split`, else RESP.
  - BEAT2: `busValid=1`. On `busAck`, go to RESP.
  - RESP: `respValid=1`. On `respReady`, go to IDLE.
- `reqReady=0` in every state except IDLE; no request pipelining.
- Bus outputs are held stable while `busValid=1` until `busAck`.
- Bus outputs are 0 when `busValid=0`.

## Timing
- Reset (async assert, sync deassert by the environment) clears:
  - state to IDLE;
  - all latched fields;
  - all outputs to 0, except `reqReady`, which reads 1 in IDLE.
- Reset mid-access abandons any beat in flight; no response is produced.
- Request accepted at edge t:
  - BEAT1 occupies cycle t+1.
  - With `busAck` in the same cycle, the non-split response is valid at cycle t+2.
  - A split access adds ≥1 cycle.
- `busAck` is ignored outside BEAT1/BEAT2.
- `respData` is held stable until `respReady`.
- Response and new-request handshakes never overlap: the next accept is the cycle after IDLE is re-entered.
- Size None issues no bus beat; a zero response follows 1 cycle after accept.

## Structure
- Shared package (Mips/Control/Signal/Memory) holds:
  - the size encoding (None/Byte/Half/Word constants and width macro);
  - the FSM state constants.
- Natural sub-module: `mips_memory_lane_shifter`, combinational.
  - Inputs: off, n, data.
  - Outputs: wideBE and wide store data.
  - Used once for enables/data; the load path uses its inverse shift inline.

## Test plan
- BYTES=4, store Word 0xDEADBEEF @0x100, ack immediately:
  - one beat, addr 0x100, BE 1111, WData 0xDEADBEEF;
  - respValid at t+2, respData 0.
- Store Half 0xABCD @0x103, split:
  - beat 1: addr 0x100, BE 1000, WData 0xCD000000;
  - beat 2: addr 0x104, BE 0001, WData 0x000000AB.
- Load Byte signed @0x102, rdata 0x00800000 → respData 0xFFFFFF80.
  - Same load unsigned → 0x00000080.
- Load Word @0xFFFFFFFE, split with wrap:
  - beat 2 addr 0x00000000;
  - rdata1 0x1122xxxx, rdata2 0xxxxx3344 → respData 0x33441122.
- Stalls and reset:
  - busAck delayed 3 cycles: bus outputs remain constant.
  - respReady low 2 cycles: response held.
  - Then assert resetN=0 during BEAT2: next cycle state is IDLE, busValid=0, no response.
- Size None:
  - no busValid;
  - respValid one cycle after accept;
  - reqReady=0 until the response handshake completes.

Source files
------------

// File: rtl/mips_memory_access_aligner_pkg.sv
// Shared size encoding, FSM states and size helper for the memory access aligner.
package mips_memory_access_aligner_pkg;

  localparam int unsigned SIZE_W = 2;

  localparam logic [SIZE_W-1:0] SIZE_NONE = 2'd0;
  localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd1;
  localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd2;
  localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT1 = 2'd1,
    ST_BEAT2 = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Number of bytes touched by an access size (0, 1, 2 or 4).
  function automatic logic [2:0] size_bytes(input logic [SIZE_W-1:0] size);
    case (size)
      SIZE_BYTE: size_bytes = 3'd1;
      SIZE_HALF: size_bytes = 3'd2;
      SIZE_WORD: size_bytes = 3'd4;
      default:   size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mips_memory_access_aligner_lane_shifter.sv
// Combinational lane shifter: double-width byte enables and store data for an offset access.
module mips_memory_lane_shifter #(
  parameter int unsigned BYTES = 4
) (
  input  logic [$clog2(BYTES)-1:0] off,
  input  logic [2:0]               n,
  input  logic [8*BYTES-1:0]       data,
  output logic [2*BYTES-1:0]       wide_be,
  output logic [16*BYTES-1:0]      wide_data
);

  localparam int unsigned OFF_W = $clog2(BYTES);

  logic [2*BYTES-1:0] mask;

  // Low n bits set, then both enables and data are moved up by the byte offset.
  always_comb begin
    mask      = ((2*BYTES)'(1) << n) - (2*BYTES)'(1);
    wide_be   = mask << off;
    wide_data = {{(8*BYTES){1'b0}}, data} << {off, 3'b000};
  end

endmodule

// File: rtl/mips_memory_access_aligner.sv
// Load/store aligner between the MEM stage and the data bus; splits boundary-crossing accesses.
module mips_memory_access_aligner
  import mips_memory_access_aligner_pkg::*;
#(
  parameter int unsigned BYTES  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                 clock,
  input  logic                 resetN,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic [ADDR_W-1:0]    reqAddr,
  input  logic [1:0]           reqSize,
  input  logic                 reqWrite,
  input  logic                 reqSigned,
  input  logic [8*BYTES-1:0]   reqData,
  output logic                 busValid,
  input  logic                 busAck,
  output logic [ADDR_W-1:0]    busAddr,
  output logic                 busWrite,
  output logic [BYTES-1:0]     busByteEnable,
  output logic [8*BYTES-1:0]   busWData,
  input  logic [8*BYTES-1:0]   busRData,
  output logic                 respValid,
  input  logic                 respReady,
  output logic [8*BYTES-1:0]   respData
);

  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned DW    = 8 * BYTES;

  state_t state, state_next;
  logic   accept, ack;

  logic [ADDR_W-1:0]  base_q;
  logic [OFF_W-1:0]   off_q;
  logic [2:0]         n_q;
  logic               write_q, signed_q, split_q;
  logic [2*BYTES-1:0] be_q;
  logic [2*DW-1:0]    wdata_q;
  logic [DW-1:0]      rdata1_q;

  logic [OFF_W-1:0]   req_off;
  logic [2:0]         req_n;
  logic [ADDR_W-1:0]  req_base;
  logic               req_split;
  logic [2*BYTES-1:0] sh_be;
  logic [2*DW-1:0]    sh_wdata;

  logic [DW-1:0]      lo, hi;
  logic [2*DW-1:0]    shifted;
  logic               fill;
  logic [DW-1:0]      load_c;

  assign req_off   = reqAddr[OFF_W-1:0];
  assign req_n     = size_bytes(reqSize);
  assign req_base  = {reqAddr[ADDR_W-1:OFF_W], OFF_W'(0)};
  assign req_split = (int'(req_off) + int'(req_n)) > int'(BYTES);

  mips_memory_lane_shifter #(.BYTES(BYTES)) u_shifter (
    .off       (req_off),
    .n         (req_n),
    .data      (reqData),
    .wide_be   (sh_be),
    .wide_data (sh_wdata)
  );

  // State register.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next-state decode and handshake strobes.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    ack        = 1'b0;
    case (state)
      ST_IDLE: if (reqValid) begin
        accept     = 1'b1;
        state_next = (reqSize == SIZE_NONE) ? ST_RESP : ST_BEAT1;
      end
      ST_BEAT1: if (busAck) begin
        ack        = 1'b1;
        state_next = split_q ? ST_BEAT2 : ST_RESP;
      end
      ST_BEAT2: if (busAck) begin
        ack        = 1'b1;
        state_next = ST_RESP;
      end
      ST_RESP: if (respReady) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Request fields captured at acceptance; first read beat kept for split loads.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      base_q   <= '0;
      off_q    <= '0;
      n_q      <= '0;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      split_q  <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata1_q <= '0;
    end else begin
      if (accept) begin
        base_q   <= req_base;
        off_q    <= req_off;
        n_q      <= req_n;
        write_q  <= reqWrite;
        signed_q <= reqSigned;
        split_q  <= req_split;
        be_q     <= sh_be;
        wdata_q  <= sh_wdata;
      end
      if (state == ST_BEAT1 && ack) rdata1_q <= busRData;
    end
  end

  // Load reassembly: undo the lane shift, keep n bytes, extend the rest.
  always_comb begin
    lo      = (state == ST_BEAT2) ? rdata1_q : busRData;
    hi      = (state == ST_BEAT2) ? busRData : '0;
    shifted = {hi, lo} >> {off_q, 3'b000};
    fill    = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      if (n_q == 3'(j)) fill = signed_q & shifted[8*j-1];
    end
    load_c = '0;
    for (int i = 0; i < int'(DW); i++) begin
      load_c[i] = (i < 8 * int'(n_q)) ? shifted[i] : fill;
    end
    if (write_q || n_q == 3'd0) load_c = '0;
  end

  // Registered outputs, driven from the state being entered.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      reqReady      <= 1'b1;
      busValid      <= 1'b0;
      busAddr       <= '0;
      busWrite      <= 1'b0;
      busByteEnable <= '0;
      busWData      <= '0;
      respValid     <= 1'b0;
      respData      <= '0;
    end else begin
      reqReady  <= (state_next == ST_IDLE);
      respValid <= (state_next == ST_RESP);
      case (state_next)
        ST_BEAT1: if (state == ST_IDLE) begin
          busValid      <= 1'b1;
          busAddr       <= req_base;
          busWrite      <= reqWrite;
          busByteEnable <= sh_be[BYTES-1:0];
          busWData      <= sh_wdata[DW-1:0];
        end
        ST_BEAT2: begin
          busValid      <= 1'b1;
          busAddr       <= base_q + ADDR_W'(BYTES);
          busWrite      <= write_q;
          busByteEnable <= be_q[2*BYTES-1:BYTES];
          busWData      <= wdata_q[2*DW-1:DW];
        end
        default: begin
          busValid      <= 1'b0;
          busAddr       <= '0;
          busWrite      <= 1'b0;
          busByteEnable <= '0;
          busWData      <= '0;
        end
      endcase
      if (state_next == ST_RESP) begin
        if (state != ST_RESP) respData <= (state == ST_IDLE) ? '0 : load_c;
      end else begin
        respData <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mips_memory_access_aligner.sv
// Directed bench for the memory access aligner with an arithmetic reference model.
module tb_mips_memory_access_aligner;

  logic        clock = 1'b0;
  logic        resetN;
  logic        reqValid, reqReady;
  logic [31:0] reqAddr;
  logic [1:0]  reqSize;
  logic        reqWrite, reqSigned;
  logic [31:0] reqData;
  logic        busValid, busAck, busWrite;
  logic [31:0] busAddr, busWData, busRData;
  logic [3:0]  busByteEnable;
  logic        respValid, respReady;
  logic [31:0] respData;

  mips_memory_access_aligner #(.BYTES(4), .ADDR_W(32)) dut (
    .clock(clock), .resetN(resetN),
    .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr), .reqSize(reqSize),
    .reqWrite(reqWrite), .reqSigned(reqSigned), .reqData(reqData),
    .busValid(busValid), .busAck(busAck), .busAddr(busAddr), .busWrite(busWrite),
    .busByteEnable(busByteEnable), .busWData(busWData), .busRData(busRData),
    .respValid(respValid), .respReady(respReady), .respData(respData)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int beat_idx = 0;

  // Expected transaction, filled by the model.
  int          exp_nbeats;
  logic [31:0] exp_addr [2];
  logic [3:0]  exp_be   [2];
  logic [31:0] exp_wd   [2];
  logic        exp_write;
  logic [31:0] exp_resp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic over the 4-byte bus.
  task automatic model(input logic [31:0] a, input logic [1:0] sz, input logic wr, input logic sg,
                       input logic [31:0] d, input logic [31:0] r1, input logic [31:0] r2);
    int off, n;
    logic [63:0] wide, comb, m;
    logic [7:0] be;
    off  = int'(a % 32'd4);
    n    = (sz == 2'd3) ? 4 : int'(sz);
    wide = {32'h0, d} << (8 * off);
    be   = 8'(((1 << n) - 1) << off);
    exp_nbeats  = (n == 0) ? 0 : ((off + n > 4) ? 2 : 1);
    exp_addr[0] = a & 32'hFFFF_FFFC;
    exp_addr[1] = exp_addr[0] + 32'd4;
    exp_be[0]   = be[3:0];
    exp_be[1]   = be[7:4];
    exp_wd[0]   = wide[31:0];
    exp_wd[1]   = wide[63:32];
    exp_write   = wr;
    comb = {(exp_nbeats == 2) ? r2 : 32'h0, r1} >> (8 * off);
    m    = (n == 0) ? 64'h0 : ((64'h1 << (8 * n)) - 64'h1);
    comb = comb & m;
    if (sg && n > 0 && comb[8*n-1]) comb = comb | ~m;
    exp_resp = (wr || n == 0) ? 32'h0 : comb[31:0];
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Tracks which beat of the current transaction the bus is presenting.
  always @(posedge clock or negedge resetN) begin
    if (!resetN)                   beat_idx <= 0;
    else if (reqValid && reqReady) beat_idx <= 0;
    else if (busValid && busAck)   beat_idx <= beat_idx + 1;
  end

  // Every-cycle comparison of bus and response against the model.
  always @(negedge clock) begin
    if (resetN) begin
      if (busValid) begin
        if (beat_idx >= exp_nbeats) check("extra_beat", 64'(beat_idx), 64'(exp_nbeats));
        else begin
          check("bus_addr",  64'(busAddr),       64'(exp_addr[beat_idx]));
          check("bus_be",    64'(busByteEnable), 64'(exp_be[beat_idx]));
          check("bus_wdata", 64'(busWData),      64'(exp_wd[beat_idx]));
          check("bus_write", 64'(busWrite),      64'(exp_write));
        end
      end else begin
        check("idle_addr",  64'(busAddr), 64'h0);
        check("idle_lanes", 64'({busWrite, busByteEnable, busWData}), 64'h0);
      end
      if (respValid) check("resp_data", 64'(respData), 64'(exp_resp));
    end
  end

  task automatic run_txn(input logic [31:0] a, input logic [1:0] sz, input logic wr, input logic sg,
                         input logic [31:0] d, input logic [31:0] r1, input logic [31:0] r2,
                         input int ack_dly, input int resp_dly, input int exp_lat, input bit rst_b2);
    int k, t_acc;
    logic [31:0] rb;
    model(a, sz, wr, sg, d, r1, r2);
    k = 0;
    @(negedge clock);
    while (!reqReady && k < 20) begin @(negedge clock); k++; end
    if (!reqReady) begin check("req_ready_timeout", 64'(reqReady), 64'h1); return; end
    reqValid = 1'b1; reqAddr = a; reqSize = sz; reqWrite = wr; reqSigned = sg; reqData = d;
    @(negedge clock);
    reqValid = 1'b0;
    t_acc = cyc;
    check("req_ready_busy", 64'(reqReady), 64'h0);
    for (int b = 0; b < exp_nbeats; b++) begin
      k = 0;
      while (!busValid && k < 20) begin @(negedge clock); k++; end
      if (!busValid) begin check("bus_valid_timeout", 64'(busValid), 64'h1); return; end
      if (rst_b2 && b == 1) begin
        #2 resetN = 1'b0;
        @(negedge clock);
        check("rst_bus_valid",  64'(busValid),  64'h0);
        check("rst_req_ready",  64'(reqReady),  64'h1);
        check("rst_resp_valid", 64'(respValid), 64'h0);
        resetN = 1'b1;
        repeat (4) begin
          @(negedge clock);
          check("post_rst_resp", 64'({respValid, busValid}), 64'h0);
        end
        return;
      end
      repeat (ack_dly) @(negedge clock);
      rb = (b == 0) ? r1 : r2;
      busAck = 1'b1; busRData = rb;
      @(negedge clock);
      busAck = 1'b0; busRData = 32'hA5A5_A5A5;
    end
    k = 0;
    while (!respValid && k < 20) begin @(negedge clock); k++; end
    if (!respValid) begin check("resp_timeout", 64'(respValid), 64'h1); return; end
    if (exp_lat >= 0) check("resp_latency", 64'(cyc - t_acc), 64'(exp_lat));
    check("resp_req_ready", 64'(reqReady), 64'h0);
    repeat (resp_dly) begin
      @(negedge clock);
      check("resp_hold", 64'(respValid), 64'h1);
    end
    respReady = 1'b1;
    @(negedge clock);
    respReady = 1'b0;
    check("resp_done", 64'({respValid, reqReady}), 64'h1);
  endtask

  initial begin
    resetN = 1'b0; reqValid = 1'b0; reqAddr = '0; reqSize = '0; reqWrite = 1'b0;
    reqSigned = 1'b0; reqData = '0; busAck = 1'b0; busRData = 32'hA5A5_A5A5; respReady = 1'b0;
    exp_nbeats = 0; exp_write = 1'b0; exp_resp = '0;
    exp_addr[0] = '0; exp_addr[1] = '0; exp_be[0] = '0; exp_be[1] = '0; exp_wd[0] = '0; exp_wd[1] = '0;
    repeat (2) @(negedge clock);
    check("reset_ready", 64'(reqReady), 64'h1);
    check("reset_outs",  64'({busValid, respValid, busWrite, busByteEnable}), 64'h0);
    check("reset_data",  64'({busAddr, respData}), 64'h0);
    resetN = 1'b1;

    // Hand-computed anchors for the model itself.
    model(32'h103, 2'd2, 1'b1, 1'b0, 32'hABCD, 32'h0, 32'h0);
    check("model_split_beats", 64'(exp_nbeats), 64'd2);
    check("model_b1", {exp_addr[0], exp_wd[0]}, 64'h0000_0100_CD00_0000);
    check("model_b2", {exp_addr[1], exp_wd[1]}, 64'h0000_0104_0000_00AB);
    check("model_be", 64'({exp_be[1], exp_be[0]}), 64'h18);
    model(32'h102, 2'd1, 1'b0, 1'b1, 32'h0, 32'h0080_0000, 32'h0);
    check("model_lb_signed", 64'(exp_resp), 64'hFFFF_FF80);
    model(32'hFFFF_FFFE, 2'd3, 1'b0, 1'b0, 32'h0, 32'h1122_5566, 32'h7788_3344);
    check("model_wrap", 64'({exp_addr[1], exp_resp}), 64'h0000_0000_3344_1122);

    run_txn(32'h100, 2'd3, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0, 32'h0, 0, 0, 1, 1'b0);
    run_txn(32'h103, 2'd2, 1'b1, 1'b0, 32'h0000_ABCD, 32'h0, 32'h0, 0, 0, -1, 1'b0);
    run_txn(32'h102, 2'd1, 1'b0, 1'b1, 32'h0, 32'h0080_0000, 32'h0, 0, 0, 1, 1'b0);
    run_txn(32'h102, 2'd1, 1'b0, 1'b0, 32'h0, 32'h0080_0000, 32'h0, 0, 0, 1, 1'b0);
    check("lb_unsigned_model", 64'(exp_resp), 64'h80);
    run_txn(32'hFFFF_FFFE, 2'd3, 1'b0, 1'b0, 32'h0, 32'h1122_5566, 32'h7788_3344, 0, 0, -1, 1'b0);
    run_txn(32'h205, 2'd2, 1'b0, 1'b1, 32'h0, 32'h12F0_AB00, 32'h0, 3, 2, -1, 1'b0);
    check("lh_stall_model", 64'(exp_resp), 64'hFFFF_F0AB);
    run_txn(32'h107, 2'd2, 1'b0, 1'b0, 32'h0, 32'hAA00_0000, 32'h0000_00BB, 1, 0, -1, 1'b1);
    run_txn(32'h040, 2'd0, 1'b1, 1'b0, 32'h1234_5678, 32'h0, 32'h0, 0, 1, 0, 1'b0);
    run_txn(32'h001, 2'd1, 1'b1, 1'b0, 32'h0000_005A, 32'h0, 32'h0, 0, 0, 1, 1'b0);
    run_txn(32'h301, 2'd3, 1'b0, 1'b1, 32'h0, 32'h8899_AABB, 32'hCCDD_EEFF, 2, 1, -1, 1'b0);

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
